// File: rtl/collision_scheduler.sv
// Round-robin collision probe scheduler: time-shares one terrain column read port between N_OBJ objects.
// Optional macro COLL_BOUNDS_EN: probe points outside the terrain report solid.
module collision_scheduler #(
  parameter int N_OBJ = 4,
  parameter int XMAX  = 639,
  parameter int YMAX  = 479,
  localparam int IDW  = (N_OBJ > 1) ? $clog2(N_OBJ) : 1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [N_OBJ-1:0]      i_req,
  input  logic [10*N_OBJ-1:0]   i_obj_x,
  input  logic [10*N_OBJ-1:0]   i_obj_y,
  input  logic [10*N_OBJ-1:0]   i_obj_radius,
  output logic [N_OBJ-1:0]      o_done,
  output logic                  o_rsp_valid,
  output logic [IDW-1:0]        o_rsp_id,
  output logic                  o_dd,
  output logic                  o_uu,
  output logic                  o_ll,
  output logic                  o_rr,
  output logic                  o_mem_rd,
  output logic [9:0]            o_mem_addr,
  input  logic [511:0]          i_mem_data,
  output logic [2:0]            o_dbg_state
);

  // Handshake: a requester holds i_req[i] high until it sees o_done[i]; o_done and
  // o_rsp_valid pulse together for one cycle and the flags are only meaningful then.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_C = 3'd1,
    S_RD_L = 3'd2,
    S_RD_R = 3'd3,
    S_CAP  = 3'd4,
    S_RESP = 3'd5
  } state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_id;
  logic [9:0]       r_x, r_y, r_r;
  logic [N_OBJ-1:0] r_done;
  logic             r_rsp_valid;
  logic [IDW-1:0]   r_rsp_id;
  logic             r_dd, r_uu, r_ll, r_rr;
  logic             r_mem_rd;
  logic [9:0]       r_mem_addr;

  logic [9:0]       w_x [N_OBJ];
  logic [9:0]       w_y [N_OBJ];
  logic [9:0]       w_r [N_OBJ];
  logic             w_gnt_found;
  logic [IDW-1:0]   w_gnt_id;
  logic [IDW:0]     w_cand;
  logic [9:0]       w_x_minus, w_x_plus, w_y_minus, w_y_plus;
  logic             w_dd_raw, w_uu_raw, w_ll_raw, w_rr_raw;
  logic             w_dd, w_uu, w_ll, w_rr;
  logic             w_unused;

  always_comb begin
    for (int i = 0; i < N_OBJ; i++) begin
      w_x[i] = i_obj_x[10*i +: 10];
      w_y[i] = i_obj_y[10*i +: 10];
      w_r[i] = i_obj_radius[10*i +: 10];
    end
  end

  // Circular search from r_rr_ptr; the first set request wins.
  always_comb begin
    w_gnt_found = 1'b0;
    w_gnt_id    = '0;
    w_cand      = '0;
    for (int k = 0; k < N_OBJ; k++) begin
      w_cand = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_cand >= (IDW+1)'(N_OBJ)) w_cand = w_cand - (IDW+1)'(N_OBJ);
      if (!w_gnt_found && i_req[w_cand[IDW-1:0]]) begin
        w_gnt_found = 1'b1;
        w_gnt_id    = w_cand[IDW-1:0];
      end
    end
  end

  assign w_x_minus = r_x - r_r;
  assign w_x_plus  = r_x + r_r;
  assign w_y_minus = r_y - r_r;
  assign w_y_plus  = r_y + r_r;

  // The column in i_mem_data is the one addressed by the previous state's read.
  assign w_dd_raw = i_mem_data[w_y_plus[8:0]];
  assign w_uu_raw = i_mem_data[w_y_minus[8:0]];
  assign w_ll_raw = i_mem_data[r_y[8:0]];
  assign w_rr_raw = i_mem_data[r_y[8:0]];

`ifdef COLL_BOUNDS_EN
  logic [10:0] w_x_sum, w_y_sum;
  logic        w_y_oob;
  assign w_x_sum = {1'b0, r_x} + {1'b0, r_r};
  assign w_y_sum = {1'b0, r_y} + {1'b0, r_r};
  assign w_y_oob = (r_y > 10'(YMAX));
  assign w_dd = w_dd_raw | (w_y_sum > 11'(YMAX));
  assign w_uu = w_uu_raw | (r_r > r_y);
  assign w_ll = w_ll_raw | (r_r > r_x) | w_y_oob;
  assign w_rr = w_rr_raw | (w_x_sum > 11'(XMAX)) | w_y_oob;
  assign w_unused = ^{w_y_plus[9], w_y_minus[9]};
`else
  assign w_dd = w_dd_raw;
  assign w_uu = w_uu_raw;
  assign w_ll = w_ll_raw;
  assign w_rr = w_rr_raw;
  assign w_unused = ^{w_y_plus[9], w_y_minus[9], r_y[9], XMAX[0], YMAX[0]};
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_x         <= '0;
      r_y         <= '0;
      r_r         <= '0;
      r_done      <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_dd        <= 1'b0;
      r_uu        <= 1'b0;
      r_ll        <= 1'b0;
      r_rr        <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_addr  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt_found) begin
            r_id       <= w_gnt_id;
            r_x        <= w_x[w_gnt_id];
            r_y        <= w_y[w_gnt_id];
            r_r        <= w_r[w_gnt_id];
            r_mem_rd   <= 1'b1;
            r_mem_addr <= w_x[w_gnt_id];
            r_state    <= S_RD_C;
          end
        end
        S_RD_C: begin
          r_mem_addr <= w_x_minus;
          r_state    <= S_RD_L;
        end
        S_RD_L: begin
          r_dd       <= w_dd;
          r_uu       <= w_uu;
          r_mem_addr <= w_x_plus;
          r_state    <= S_RD_R;
        end
        S_RD_R: begin
          r_ll     <= w_ll;
          r_mem_rd <= 1'b0;
          r_state  <= S_CAP;
        end
        S_CAP: begin
          r_rr         <= w_rr;
          r_rsp_valid  <= 1'b1;
          r_rsp_id     <= r_id;
          r_done[r_id] <= 1'b1;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_done      <= '0;
          r_rr_ptr    <= (r_id == IDW'(N_OBJ-1)) ? '0 : r_id + 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_done      = r_done;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_id    = r_rsp_id;
  assign o_dd        = r_dd;
  assign o_uu        = r_uu;
  assign o_ll        = r_ll;
  assign o_rr        = r_rr;
  assign o_mem_rd    = r_mem_rd;
  assign o_mem_addr  = r_mem_addr;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_collision_scheduler.sv
// Directed bench for collision_scheduler: terrain RAM model, read-address log, immediate-assertion checks.
module tb_collision_scheduler;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [39:0]  obj_x, obj_y, obj_r;
  logic [3:0]   done;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic         dd, uu, ll, rr;
  logic         mem_rd;
  logic [9:0]   mem_addr;
  logic [511:0] mem_data;
  logic [2:0]   dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [511:0] terrain [1024];
  logic [9:0]   rd_q [$];

  collision_scheduler dut (
    .i_clk        (clk),
    .i_reset      (reset),
    .i_req        (req),
    .i_obj_x      (obj_x),
    .i_obj_y      (obj_y),
    .i_obj_radius (obj_r),
    .o_done       (done),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_id     (rsp_id),
    .o_dd         (dd),
    .o_uu         (uu),
    .o_ll         (ll),
    .o_rr         (rr),
    .o_mem_rd     (mem_rd),
    .o_mem_addr   (mem_addr),
    .i_mem_data   (mem_data),
    .o_dbg_state  (dbg_state)
  );

  // Clock and terrain RAM model: data valid the cycle after the read strobe.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_rd) begin
      mem_data <= terrain[mem_addr];
      rd_q.push_back(mem_addr);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_obj(input int i, input int x, input int y, input int r);
    obj_x[10*i +: 10] = x[9:0];
    obj_y[10*i +: 10] = y[9:0];
    obj_r[10*i +: 10] = r[9:0];
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    req   = '0;
    step(1);
    reset = 1'b0;
  endtask

  task automatic wait_rsp(input string tag, input int exp_cyc);
    int cyc;
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      cyc++;
      if (rsp_valid) break;
    end
    check({tag, "_latency"}, cyc, exp_cyc);
  endtask

  task automatic check_reads(input string tag, input int a0, input int a1, input int a2);
    int exp_a [3];
    exp_a = '{a0, a1, a2};
    check({tag, "_nreads"}, rd_q.size(), 3);
    for (int i = 0; i < 3; i++)
      check({tag, "_addr"}, (i < rd_q.size()) ? 64'(rd_q[i]) : 64'hFFFF, exp_a[i]);
  endtask

  initial begin
    int nv;
    int exp_order [5];
    int exp_lat [5];
    for (int c = 0; c < 1024; c++) terrain[c] = '0;
    mem_data = '0;
    reset = 1'b1;
    req   = '0;
    obj_x = '0;
    obj_y = '0;
    obj_r = '0;

    // Reset state
    step(3);
    check("rst_state", dbg_state, 0);
    check("rst_done", done, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_flags", {dd, uu, ll, rr}, 0);
    check("rst_mem_rd", mem_rd, 0);
    check("rst_mem_addr", mem_addr, 0);
    reset = 1'b0;
    step(1);

    // Single probe: DD from row 208 of column 100
    terrain[100][208] = 1'b1;
    set_obj(0, 100, 200, 8);
    rd_q.delete();
    req = 4'b0001;
    wait_rsp("t2", 5);
    check("t2_rsp_id", rsp_id, 0);
    check("t2_done", done, 4'b0001);
    check("t2_flags", {dd, uu, ll, rr}, 4'b1000);
    check_reads("t2", 100, 92, 108);
    req = 4'b0000;
    step(1);
    check("t2_rsp_pulse", rsp_valid, 0);
    check("t2_done_pulse", done, 0);

    // Reset while in RD_L discards the probe and clears held flags
    rd_q.delete();
    req = 4'b0001;
    step(2);
    check("t1_in_rdl", dbg_state, 2);
    check("t1_rdl_addr", mem_addr, 92);
    check("t1_flags_held", {dd, uu, ll, rr}, 4'b1000);
    reset = 1'b1;
    req   = 4'b0000;
    step(1);
    check("t1_state", dbg_state, 0);
    check("t1_mem_rd", mem_rd, 0);
    check("t1_mem_addr", mem_addr, 0);
    check("t1_flags", {dd, uu, ll, rr}, 0);
    check("t1_done", done, 0);
    reset = 1'b0;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (rsp_valid) nv++;
    end
    check("t1_no_rsp", nv, 0);

    // Round robin with all four requesting; obj0 re-raises after id2 is served
    pulse_reset();
    set_obj(0, 100, 200, 8);
    set_obj(1, 200, 200, 8);
    set_obj(2, 300, 200, 8);
    set_obj(3, 400, 200, 8);
    exp_order = '{0, 1, 2, 3, 0};
    exp_lat   = '{5, 6, 6, 6, 6};
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_rsp("t3", exp_lat[i]);
      check("t3_rsp_id", rsp_id, exp_order[i]);
      check("t3_dd", dd, (exp_order[i] == 0) ? 1 : 0);
      req[rsp_id] = 1'b0;
      if (i == 2) req[0] = 1'b1;
    end
    req = 4'b0101;
    wait_rsp("t3b", 6);
    check("t3b_rsp_id", rsp_id, 2);
    check("t3b_done", done, 4'b0100);
    req = 4'b0000;
    step(1);

    // Coordinates latched at grant: obj_x changes the cycle after grant
    pulse_reset();
    terrain[45][60]  = 1'b1;
    terrain[305][60] = 1'b1;
    set_obj(0, 50, 60, 5);
    rd_q.delete();
    req = 4'b0001;
    step(1);
    obj_x[9:0] = 10'd300;
    wait_rsp("t4", 4);
    check("t4_flags", {dd, uu, ll, rr}, 4'b0010);
    check_reads("t4", 50, 45, 55);
    req = 4'b0000;
    step(1);

    // Left/top edge: x-r wraps to 1020, y-r wraps to row 506
    pulse_reset();
`ifndef COLL_BOUNDS_EN
    terrain[1020][2] = 1'b1;
    terrain[4][506]  = 1'b1;
`endif
    set_obj(0, 4, 2, 8);
    rd_q.delete();
    req = 4'b0001;
    wait_rsp("t5", 5);
    check("t5_flags", {dd, uu, ll, rr}, 4'b0110);
    check_reads("t5", 4, 1020, 12);
    req = 4'b0000;
    step(1);

    // Right/bottom edge against empty terrain
    pulse_reset();
    set_obj(0, 635, 470, 10);
    rd_q.delete();
    req = 4'b0001;
    wait_rsp("t6", 5);
`ifdef COLL_BOUNDS_EN
    check("t6_flags", {dd, uu, ll, rr}, 4'b1001);
`else
    check("t6_flags", {dd, uu, ll, rr}, 4'b0000);
`endif
    check_reads("t6", 635, 625, 645);
    req = 4'b0000;
    step(2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
